// File: rtl/rotate_led_pkg.sv
// Shared constants and helpers for the rotating one-hot LED bar.
package rotate_led_pkg;

    localparam int unsigned N_LED_DEF    = 5;
    localparam int unsigned FAST_DIV_DEF = 2;
    localparam int unsigned SLOW_DIV_DEF = 8;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Widest LED bar the reset-pattern helper can describe.
    localparam int unsigned ONE_HOT_MAX = 64;

    function automatic logic [ONE_HOT_MAX-1:0] one_hot_init(input int unsigned n);
        logic [ONE_HOT_MAX-1:0] v;
        v = '0;
        if (n > 0) v[0] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rotate_led_tick_gen.sv
// Prescaler: turns the base clock into single-cycle step ticks at FAST_DIV or SLOW_DIV.
module rotate_led_tick_gen
    import rotate_led_pkg::*;
#(
    parameter int unsigned FAST_DIV = FAST_DIV_DEF,
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pause,
    input  logic i_fast,
    output logic o_tick
);

    localparam int unsigned CNT_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_last;
    logic             w_tick;

    // >= rather than == so a slow-to-fast switch past FAST_LAST ticks at once.
    always_comb begin
        w_last    = i_fast ? FAST_LAST : SLOW_LAST;
        w_tick    = !i_pause && (r_cnt >= w_last);
        w_cnt_nxt = r_cnt;
        if (!i_pause) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tick = w_tick;

endmodule

// File: rtl/rotate_led_core.sv
// Rotating one-hot LED bar with speed, direction and pause control.
// Defining ROTATE_LED_POS_EN adds the binary index output pos.
module rotate_led_core
    import rotate_led_pkg::*;
#(
    parameter int unsigned N_LED    = N_LED_DEF,
    parameter int unsigned FAST_DIV = FAST_DIV_DEF,
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             fast,
    input  logic             rt,
    output logic [N_LED-1:0] dout
`ifdef ROTATE_LED_POS_EN
    ,
    output logic [$clog2(N_LED)-1:0] pos
`endif
);

    localparam logic [ONE_HOT_MAX-1:0] INIT_FULL = one_hot_init(N_LED);
    localparam logic [N_LED-1:0]       INIT      = INIT_FULL[N_LED-1:0];

    logic [N_LED-1:0] r_dout;
    logic [N_LED-1:0] w_dout_nxt;
    logic             w_tick;
    logic             w_onehot;

    rotate_led_tick_gen #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (reset),
        .i_pause (pause),
        .i_fast  (fast),
        .o_tick  (w_tick)
    );

    // A corrupted pattern is repaired even while paused.
    always_comb begin
        w_onehot   = (r_dout != '0) && ((r_dout & (r_dout - 1'b1)) == '0);
        w_dout_nxt = r_dout;
        if (!w_onehot) begin
            w_dout_nxt = INIT;
        end else if (w_tick) begin
            if (rt == DIR_RIGHT) begin
                w_dout_nxt = {r_dout[0], r_dout[N_LED-1:1]};
            end else begin
                w_dout_nxt = {r_dout[N_LED-2:0], r_dout[N_LED-1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= INIT;
        end else begin
            r_dout <= w_dout_nxt;
        end
    end

    assign dout = r_dout;

`ifdef ROTATE_LED_POS_EN
    localparam int unsigned        POS_W    = $clog2(N_LED);
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(N_LED - 1);

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;

    always_comb begin
        w_pos_nxt = r_pos;
        if (!w_onehot) begin
            w_pos_nxt = '0;
        end else if (w_tick) begin
            if (rt == DIR_RIGHT) begin
                w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
            end else begin
                w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos <= '0;
        end else begin
            r_pos <= w_pos_nxt;
        end
    end

    assign pos = r_pos;
`endif

endmodule

// File: tb/tb_rotate_led_core.sv
// Scoreboard bench for rotate_led_core at N_LED=5, FAST_DIV=2, SLOW_DIV=8.
// Checks pos too when ROTATE_LED_POS_EN is defined.
module tb_rotate_led_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic       fast;
    logic       rt;
    logic [4:0] dout;
`ifdef ROTATE_LED_POS_EN
    logic [2:0] pos;
`endif

    rotate_led_core #(
        .N_LED    (5),
        .FAST_DIV (2),
        .SLOW_DIV (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pause (pause),
        .fast  (fast),
        .rt    (rt),
        .dout  (dout)
`ifdef ROTATE_LED_POS_EN
        ,
        .pos   (pos)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [4:0] dout;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   mon_ep;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_now(input logic [4:0] e, input string name);
        exp_t x;
        x.dout = e;
        x.name = name;
        q.push_back(x);
    endtask

    // Wait n rising edges; after each, queue the value dout must hold.
    task automatic cycn(input int n, input logic [4:0] e, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            expect_now(e, name);
        end
    endtask

    // Monitor: one pending expectation is compared at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_x = q.pop_front();
                n_tests++;
                if (dout !== mon_x.dout) begin
                    n_fail++;
                    $display("FAIL %s: dout=%b expected %b at %0t",
                             mon_x.name, dout, mon_x.dout, $time);
                end
`ifdef ROTATE_LED_POS_EN
                mon_ep = 0;
                for (int i = 0; i < 5; i++) if (mon_x.dout[i]) mon_ep = i;
                n_tests++;
                if (pos !== 3'(mon_ep)) begin
                    n_fail++;
                    $display("FAIL %s_pos: pos=%0d expected %0d at %0t",
                             mon_x.name, pos, mon_ep, $time);
                end
`endif
            end
        end
    end

    initial begin
        reset = 1'b0;
        pause = 1'b0;
        fast  = 1'b1;
        rt    = 1'b1;
        cycn(2, 5'b00001, "reset_hold");
        reset = 1'b1;

        // Fast right rotation, step every 2nd edge, LSB wraps to MSB.
        cycn(1, 5'b00001, "release_first_edge");
        cycn(2, 5'b10000, "right_10000");
        cycn(2, 5'b01000, "right_01000");
        cycn(2, 5'b00100, "right_00100");
        cycn(2, 5'b00010, "right_00010");
        cycn(1, 5'b00001, "right_wrap");

        // Pause after cnt=1: held two edges, step on the first edge after release.
        cycn(1, 5'b00001, "pre_pause");
        pause = 1'b1;
        cycn(2, 5'b00001, "paused_hold");
        pause = 1'b0;
        cycn(1, 5'b10000, "resume_step");

        cycn(1, 5'b10000, "to_00100_a");
        cycn(2, 5'b01000, "to_00100_b");
        cycn(1, 5'b00100, "to_00100_c");

        // Left rotation, MSB wraps to LSB.
        rt = 1'b0;
        cycn(1, 5'b00100, "left_wait");
        cycn(2, 5'b01000, "left_01000");
        cycn(2, 5'b10000, "left_10000");
        cycn(1, 5'b00001, "left_wrap");

        // Slow right rotation, then slow-to-fast switch at cnt=5.
        fast = 1'b0;
        rt   = 1'b1;
        cycn(7, 5'b00001, "slow_wait1");
        cycn(8, 5'b10000, "slow_step1");
        cycn(1, 5'b01000, "slow_step2");
        cycn(5, 5'b01000, "slow_cnt5");
        fast = 1'b1;
        cycn(1, 5'b00100, "slow_to_fast");

        // Slow left to 01000, run cnt to 3, then assert reset mid-cycle.
        fast = 1'b0;
        rt   = 1'b0;
        cycn(7, 5'b00100, "slow_left_wait");
        cycn(1, 5'b01000, "slow_left_step");
        cycn(2, 5'b01000, "slow_left_cnt");
        @(posedge clk);
        #5;
        reset = 1'b0;
        expect_now(5'b00001, "async_reset");
        cycn(2, 5'b00001, "reset_hold2");
        reset = 1'b1;
        fast  = 1'b1;
        rt    = 1'b1;
        cycn(1, 5'b00001, "release2_first_edge");
        cycn(2, 5'b10000, "release2_10000");
        cycn(2, 5'b01000, "release2_01000");
        cycn(1, 5'b00100, "release2_00100");

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
